bttn_arbiter: RTL and testbench

Command arbiter between the button front-ends (long-press reset detector, per-button pulse generators) and the game state machine. Latches one-cycle press pulses, grants one command at a time over a valid/ready handshake, and enforces a cooldown between commands so bounce or rapid presses cannot flood the game logic. The reset request always outranks action buttons.

---
 rtl/bttn_arbiter.sv | 147 ++++++++++++++
 tb/tb_bttn_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bttn_arbiter.sv
// Button command arbiter: latches press pulses, grants one command at a
// time over valid/ready, enforces a cooldown; reset requests outrank buttons.
// Ports: clk, rst (sync, active high), rst_req, bttn_pulse[N_BTTN],
//   cmd_ready -> cmd_valid, cmd_id (0 = game reset, i+1 = button i),
//   pending[N_BTTN], busy.
// Optional: define BTTN_RR_EN for round-robin button arbitration
//   (default: fixed priority, lowest index wins).
module bttn_arbiter #(
  parameter int N_BTTN       = 4,
  parameter int COOLDOWN_CYC = 12500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rst_req,
  input  logic [N_BTTN-1:0]             bttn_pulse,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [$clog2(N_BTTN+1)-1:0]   cmd_id,
  output logic [N_BTTN-1:0]             pending,
  output logic                          busy
);

  localparam int IW   = $clog2(N_BTTN + 1);
  localparam int CW   = (COOLDOWN_CYC > 0) ?
                        $clog2(COOLDOWN_CYC + 1) : 1;
  localparam int LAST = (COOLDOWN_CYC > 0) ?
                        COOLDOWN_CYC - 1 : 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     id_n;
  logic [IW-1:0]     sel_id;
  logic [CW-1:0]     cnt, cnt_n;
  logic              rst_pend, rst_pend_n;
  logic [N_BTTN-1:0] pend_n;
  logic [N_BTTN-1:0] btn_clr;
  logic              accept;
  logic              rst_acc;

  assign cmd_valid = (state == GRANT);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rst_acc   = accept && (cmd_id == '0);

`ifdef BTTN_RR_EN
  localparam int PW = (N_BTTN > 1) ? $clog2(N_BTTN) : 1;

  logic [PW-1:0] ptr, ptr_n;

  // Search starts at ptr; walking k downward lets the
  // smallest offset from ptr win.
  always_comb begin
    int idx;
    idx    = 0;
    sel_id = '0;
    for (int k = N_BTTN - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_BTTN;
      if (pending[idx]) sel_id = IW'(idx + 1);
    end
  end

  // Pointer lands one past the accepted button.
  always_comb begin
    ptr_n = ptr;
    if (accept && cmd_id != '0) begin
      if (cmd_id == IW'(N_BTTN)) ptr_n = '0;
      else                       ptr_n = PW'(cmd_id);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_n;
  end
`else
  always_comb begin
    sel_id = '0;
    for (int i = N_BTTN - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = IW'(i + 1);
    end
  end
`endif

  // Set beats clear, except a granted reset wipes all
  // button requests outright.
  always_comb begin
    for (int i = 0; i < N_BTTN; i++) begin
      btn_clr[i] = accept && (cmd_id == IW'(i + 1));
    end
    if (rst_acc) pend_n = '0;
    else         pend_n = bttn_pulse | (pending & ~btn_clr);
    rst_pend_n = rst_req | (rst_pend & ~rst_acc);
  end

  always_comb begin
    state_n = state;
    id_n    = cmd_id;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (rst_pend || (|pending)) begin
          state_n = GRANT;
          id_n    = rst_pend ? '0 : sel_id;
        end
      end
      GRANT: begin
        if (cmd_ready) begin
          cnt_n   = '0;
          state_n = (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (rst_req || rst_pend) begin
          state_n = GRANT;
          id_n    = '0;
        end else if (cnt == CW'(LAST)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd_id   <= '0;
      cnt      <= '0;
      rst_pend <= 1'b0;
      pending  <= '0;
    end else begin
      state    <= state_n;
      cmd_id   <= id_n;
      cnt      <= cnt_n;
      rst_pend <= rst_pend_n;
      pending  <= pend_n;
    end
  end

endmodule

// File: tb/tb_bttn_arbiter.sv
// Directed bench for bttn_arbiter, N_BTTN=4, COOLDOWN_CYC=4.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_bttn_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req;
  logic [3:0] bttn_pulse;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic [3:0] pending;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  bttn_arbiter #(
    .N_BTTN(4),
    .COOLDOWN_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rst_req(rst_req),
    .bttn_pulse(bttn_pulse),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_id(cmd_id),
    .pending(pending),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int order[3];

  initial begin
`ifdef BTTN_RR_EN
    order = '{4, 1, 2};
`else
    order = '{1, 2, 4};
`endif
    rst = 1'b1;
    rst_req = 1'b0;
    bttn_pulse = '0;
    cmd_ready = 1'b1;
    ticks(2);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_id", cmd_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: single press on button 2
    bttn_pulse = 4'b0100;
    tick();
    bttn_pulse = '0;
    chk("t1_pend", pending, 4'b0100);
    chk("t1_valid_early", cmd_valid, 0);
    tick();
    chk("t1_valid", cmd_valid, 1);
    chk("t1_id", cmd_id, 3);
    tick();
    chk("t1_acc_valid", cmd_valid, 0);
    chk("t1_acc_pend", pending, 0);
    chk("t1_busy_cd", busy, 1);
    ticks(3);
    chk("t1_busy_last", busy, 1);
    tick();
    chk("t1_busy_off", busy, 0);

    // 2: stall with button 1, reset request arrives mid-stall
    cmd_ready = 1'b0;
    bttn_pulse = 4'b0010;
    tick();
    bttn_pulse = '0;
    tick();
    chk("t2_id", cmd_id, 2);
    rst_req = 1'b1;
    bttn_pulse = 4'b0001;
    tick();
    rst_req = 1'b0;
    bttn_pulse = '0;
    chk("t2_hold_id", cmd_id, 2);
    chk("t2_hold_valid", cmd_valid, 1);
    tick();
    chk("t2_hold_id2", cmd_id, 2);
    cmd_ready = 1'b1;
    tick();
    chk("t2_acc_valid", cmd_valid, 0);
    chk("t2_acc_pend", pending, 4'b0001);
    tick();
    chk("t2_rst_valid", cmd_valid, 1);
    chk("t2_rst_id", cmd_id, 0);
    tick();
    chk("t2_rst_acc_valid", cmd_valid, 0);
    chk("t2_rst_acc_pend", pending, 0);
    ticks(4);
    chk("t2_idle_busy", busy, 0);
    tick();
    chk("t2_no_grant", cmd_valid, 0);

    // 3: reset request aborts cooldown at count 1
    bttn_pulse = 4'b0001;
    tick();
    bttn_pulse = '0;
    tick();
    chk("t3_id", cmd_id, 1);
    tick();
    chk("t3_acc_valid", cmd_valid, 0);
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    chk("t3_abort_valid", cmd_valid, 1);
    chk("t3_abort_id", cmd_id, 0);
    tick();
    chk("t3_rst_acc", cmd_valid, 0);
    ticks(4);
    chk("t3_idle_busy", busy, 0);

    // 4: preset (RR pointer -> 2), then simultaneous presses
    bttn_pulse = 4'b0010;
    tick();
    bttn_pulse = '0;
    tick();
    chk("t4_pre_id", cmd_id, 2);
    ticks(5);
    chk("t4_pre_idle", busy, 0);
    bttn_pulse = 4'b1011;
    tick();
    bttn_pulse = '0;
    chk("t4_pend", pending, 4'b1011);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_valid", cmd_valid, 1);
      chk("t4_order", cmd_id, order[k]);
      tick();
      ticks(4);
    end
    chk("t4_pend_end", pending, 0);
    chk("t4_busy_end", busy, 0);

    // 5: re-press on the acceptance edge
    bttn_pulse = 4'b0001;
    tick();
    bttn_pulse = '0;
    tick();
    chk("t5_id", cmd_id, 1);
    bttn_pulse = 4'b0001;
    tick();
    bttn_pulse = '0;
    chk("t5_pend_kept", pending, 4'b0001);
    chk("t5_acc_valid", cmd_valid, 0);
    ticks(4);
    chk("t5_cd_done", cmd_valid, 0);
    tick();
    chk("t5_regrant_valid", cmd_valid, 1);
    chk("t5_regrant_id", cmd_id, 1);
    tick();
    chk("t5_pend_clr", pending, 0);
    ticks(4);

    // 6: sync reset while a command is presented
    cmd_ready = 1'b0;
    bttn_pulse = 4'b0100;
    tick();
    bttn_pulse = 4'b0001;
    tick();
    bttn_pulse = '0;
    chk("t6_valid", cmd_valid, 1);
    chk("t6_pend", pending, 4'b0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid_rst", cmd_valid, 0);
    chk("t6_pend_rst", pending, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_id_rst", cmd_id, 0);
    tick();
    chk("t6_stay_idle", cmd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
